traffic_light_ctrl: RTL

Timed two-approach traffic-light sequencer that produces the 2-bit colour codes consumed by the per-approach colour LED drivers. It runs the north-south (NS) and east-west (EW) phases through green, yellow and all-red intervals on a prescaled tick. It also services a latched pedestrian request with an early green cut-off and a walk interval. It sits between the board clock/reset and the two LED driver instances.

---
 rtl/traffic_light_ctrl_pkg.sv | 54 +++++
 rtl/traffic_light_ctrl_if.sv | 28 ++
 rtl/traffic_light_ctrl_tick_prescaler.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types for the traffic-light sequencer: colour codes, FSM states
// and small decode helpers used by the controller.
package traffic_light_ctrl_pkg;

   typedef enum logic [1:0] {
      YELLOW = 2'd0,
      RED    = 2'd1,
      GREEN  = 2'd2
   } light_t;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      RED_A     = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      RED_B     = 3'd5
   } state_t;

   function automatic state_t next_state(input state_t s);
      case (s)
         NS_GREEN:  return NS_YELLOW;
         NS_YELLOW: return RED_A;
         RED_A:     return EW_GREEN;
         EW_GREEN:  return EW_YELLOW;
         EW_YELLOW: return RED_B;
         RED_B:     return NS_GREEN;
         default:   return NS_GREEN;
      endcase
   endfunction

   function automatic light_t ns_decode(input state_t s);
      case (s)
         NS_GREEN:  return GREEN;
         NS_YELLOW: return YELLOW;
         default:   return RED;
      endcase
   endfunction

   function automatic light_t ew_decode(input state_t s);
      case (s)
         EW_GREEN:  return GREEN;
         EW_YELLOW: return YELLOW;
         default:   return RED;
      endcase
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Pedestrian handshake and colour-code outputs of the sequencer; the
// slave side is the controller, the master side drives the request.
interface traffic_light_ctrl_if;
   import traffic_light_ctrl_pkg::*;

   logic   ped_req;
   logic   ped_ack;
   logic   ped_walk;
   light_t ns_light;
   light_t ew_light;

   modport master (
      output ped_req,
      input  ped_ack,
      input  ped_walk,
      input  ns_light,
      input  ew_light
   );

   modport slave (
      input  ped_req,
      output ped_ack,
      output ped_walk,
      output ns_light,
      output ew_light
   );

endinterface

// File: rtl/traffic_light_ctrl_tick_prescaler.sv
// Free-running divider: tick is high in the cycle the count reaches
// TICK_DIV-1, and the count wraps to zero on that same edge.
module tick_prescaler #(
   parameter int TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV) + 1;

   logic [CW-1:0] count_r;

   assign tick = (count_r == CW'(TICK_DIV - 1));

   // Prescaler count with synchronous reset and wrap on tick
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (tick) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_r + CW'(1);
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach traffic-light sequencer with pedestrian early cut-off and
// walk-extended all-red; outputs are registered and decoded from state.
module traffic_light_ctrl
   import traffic_light_ctrl_pkg::*;
#(
   parameter int TICK_DIV        = 100000000,
   parameter int GREEN_TICKS     = 10,
   parameter int MIN_GREEN_TICKS = 4,
   parameter int YELLOW_TICKS    = 3,
   parameter int ALLRED_TICKS    = 1,
   parameter int WALK_TICKS      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   traffic_light_ctrl_if.slave  bus
);

   localparam int RED_MAX = ALLRED_TICKS + WALK_TICKS;
   localparam int PW      = $clog2(max3(GREEN_TICKS, YELLOW_TICKS, RED_MAX)) + 1;

   logic          tick;
   state_t        state_r;
   logic [PW-1:0] phase_cnt_r;
   logic          ped_pending_r;
   logic          ped_armed_r;
   logic          walk_active_r;
   logic          ped_ack_r;
   light_t        ns_light_r;
   light_t        ew_light_r;

   logic          in_green_s;
   logic          in_yellow_s;
   logic          in_red_s;
   logic          exit_s;
   logic          step_s;
   logic          accept_s;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Phase-exit and pedestrian-accept decisions for the current cycle
   always_comb begin
      in_green_s  = (state_r == NS_GREEN)  || (state_r == EW_GREEN);
      in_yellow_s = (state_r == NS_YELLOW) || (state_r == EW_YELLOW);
      in_red_s    = (state_r == RED_A)     || (state_r == RED_B);
      exit_s      = 1'b0;
      case (state_r)
         NS_GREEN, EW_GREEN:
            exit_s = (phase_cnt_r == PW'(GREEN_TICKS - 1)) ||
                     (ped_pending_r && (phase_cnt_r >= PW'(MIN_GREEN_TICKS - 1)));
         NS_YELLOW, EW_YELLOW:
            exit_s = (phase_cnt_r == PW'(YELLOW_TICKS - 1));
         RED_A, RED_B:
            if (walk_active_r) begin
               exit_s = (phase_cnt_r == PW'(RED_MAX - 1));
            end else begin
               exit_s = (phase_cnt_r == PW'(ALLRED_TICKS - 1));
            end
         default:
            exit_s = 1'b0;
      endcase
      step_s = tick && exit_s;
      // Only a request already pending when green ended is served at this red
      accept_s = step_s && in_yellow_s && ped_armed_r;
   end

   // FSM, phase counter, pedestrian bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= NS_GREEN;
         phase_cnt_r   <= {PW{1'b0}};
         ped_pending_r <= 1'b0;
         ped_armed_r   <= 1'b0;
         walk_active_r <= 1'b0;
         ped_ack_r     <= 1'b0;
         ns_light_r    <= GREEN;
         ew_light_r    <= RED;
      end else begin
         ped_ack_r     <= accept_s;
         ped_pending_r <= bus.ped_req | (ped_pending_r & ~accept_s);

         if (step_s) begin
            state_r     <= next_state(state_r);
            phase_cnt_r <= {PW{1'b0}};
            ns_light_r  <= ns_decode(next_state(state_r));
            ew_light_r  <= ew_decode(next_state(state_r));
         end else if (tick) begin
            phase_cnt_r <= phase_cnt_r + PW'(1);
         end else begin
            phase_cnt_r <= phase_cnt_r;
         end

         if (step_s && in_green_s) begin
            ped_armed_r <= ped_pending_r;
         end else if (accept_s) begin
            ped_armed_r <= 1'b0;
         end else begin
            ped_armed_r <= ped_armed_r;
         end

         if (accept_s) begin
            walk_active_r <= 1'b1;
         end else if (step_s && in_red_s) begin
            walk_active_r <= 1'b0;
         end else begin
            walk_active_r <= walk_active_r;
         end
      end
   end

   assign bus.ped_ack  = ped_ack_r;
   assign bus.ped_walk = walk_active_r;
   assign bus.ns_light = ns_light_r;
   assign bus.ew_light = ew_light_r;

endmodule
